// File: rtl/dvp_camera_source_if.sv
// DVP pixel bus: PCLK, VSYNC, HREF and the 8-bit data byte.
//
// Handshake: the bus has no backpressure. A byte on D is valid at the rising
// edge of PCLK while HREF=1; VSYNC frames the picture. The master drives all
// four signals and the slave only observes them.
interface dvp_camera_source_if;
    logic       PCLK;
    logic       VSYNC;
    logic       HREF;
    logic [7:0] D;

    modport master (output PCLK, VSYNC, HREF, D);
    modport slave  (input  PCLK, VSYNC, HREF, D);
endinterface

// File: rtl/dvp_camera_source.sv
// dvp_camera_source: OV7670-style DVP transmitter producing a synthetic
// YUV422 frame (byte order Cb,Y0,Cr,Y1) clocked from CLOCK_24.
//
// PCLK = CLOCK_24/2. Every output and counter changes only on the CLOCK_24
// edge where PCLK falls, so the receiver sees stable data at PCLK rise.
//
// Configuration macro TEST_BARS_EN: when defined, the active picture is
// 8 vertical colour bars; when undefined, a luma gradient
// Y = x + row + frame_cnt (mod 256) with neutral chroma is sent instead.
module dvp_camera_source #(
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 144,
    parameter int V_ACTIVE  = 480,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 17,
    parameter int VFP_LINES = 10
) (
    input  logic                       CLOCK_24,
    input  logic                       rst_n,
    input  logic                       enable,
    dvp_camera_source_if.master        dvp,
    output logic [7:0]                 frame_cnt,
    output logic                       frame_done,
    output logic [2:0]                 state_dbg
);

    localparam int H_BYTES = 2 * (H_ACTIVE + H_BLANK);
    localparam int HW      = $clog2(H_BYTES);
    localparam int V_TOTAL = VS_LINES + VBP_LINES + V_ACTIVE + VFP_LINES;
    localparam int LW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST    = HW'(H_BYTES - 1);
    localparam logic [HW-1:0] H_ACT_LIM = HW'(2 * H_ACTIVE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBP    = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFP    = 3'd4
    } state_t;

    state_t        state;
    logic [HW-1:0] h_cnt;
    logic [LW-1:0] line_cnt;
    logic          pclk_q;
    logic          vsync_q;
    logic          href_q;
    logic [7:0]    d_q;

    // Position and outputs of the byte that starts at the next PCLK fall.
    state_t        state_nxt;
    logic [HW-1:0] h_nxt;
    logic [LW-1:0] line_nxt;
    logic [LW-1:0] line_last;
    logic          frame_end;
    logic          vsync_nxt;
    logic          href_nxt;
    logic [7:0]    d_nxt;
    logic [HW-2:0] pix_x;
    logic [1:0]    byte_sel;

    assign dvp.PCLK  = pclk_q;
    assign dvp.VSYNC = vsync_q;
    assign dvp.HREF  = href_q;
    assign dvp.D     = d_q;
    assign state_dbg = state;

`ifdef TEST_BARS_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    function automatic logic [7:0] bar_y(input logic [2:0] k);
        case (k)
            3'd0: return 8'd235;
            3'd1: return 8'd210;
            3'd2: return 8'd170;
            3'd3: return 8'd145;
            3'd4: return 8'd106;
            3'd5: return 8'd81;
            3'd6: return 8'd41;
            default: return 8'd16;
        endcase
    endfunction

    function automatic logic [7:0] bar_cb(input logic [2:0] k);
        case (k)
            3'd0: return 8'd128;
            3'd1: return 8'd16;
            3'd2: return 8'd166;
            3'd3: return 8'd54;
            3'd4: return 8'd202;
            3'd5: return 8'd90;
            3'd6: return 8'd240;
            default: return 8'd128;
        endcase
    endfunction

    function automatic logic [7:0] bar_cr(input logic [2:0] k);
        case (k)
            3'd0: return 8'd128;
            3'd1: return 8'd146;
            3'd2: return 8'd16;
            3'd3: return 8'd34;
            3'd4: return 8'd222;
            3'd5: return 8'd240;
            3'd6: return 8'd110;
            default: return 8'd128;
        endcase
    endfunction

    logic [2:0]    bar_k;
    logic [2:0]    bar_k_even;
    logic [HW-2:0] pix_x_even;
`endif

    // Last line index of the current vertical state.
    always_comb begin
        line_last = '0;
        case (state)
            S_VSYNC:  line_last = LW'(VS_LINES - 1);
            S_VBP:    line_last = LW'(VBP_LINES - 1);
            S_ACTIVE: line_last = LW'(V_ACTIVE - 1);
            S_VFP:    line_last = LW'(VFP_LINES - 1);
            default:  line_last = '0;
        endcase
    end

    // Advance the byte/line position by one byte; state moves only on line wrap.
    always_comb begin
        state_nxt = state;
        h_nxt     = h_cnt;
        line_nxt  = line_cnt;
        frame_end = 1'b0;
        if (state == S_IDLE) begin
            if (enable) begin
                state_nxt = S_VSYNC;
                h_nxt     = '0;
                line_nxt  = '0;
            end
        end else if (h_cnt == H_LAST) begin
            h_nxt = '0;
            if (line_cnt == line_last) begin
                line_nxt = '0;
                case (state)
                    S_VSYNC:  state_nxt = S_VBP;
                    S_VBP:    state_nxt = S_ACTIVE;
                    S_ACTIVE: state_nxt = S_VFP;
                    S_VFP: begin
                        frame_end = 1'b1;
                        state_nxt = enable ? S_VSYNC : S_IDLE;
                    end
                    default:  state_nxt = S_IDLE;
                endcase
            end else begin
                line_nxt = line_cnt + 1'b1;
            end
        end else begin
            h_nxt = h_cnt + 1'b1;
        end
    end

    // Decode sync strobes and the pixel byte for the next byte position.
    always_comb begin
        pix_x     = h_nxt[HW-1:1];
        byte_sel  = h_nxt[1:0];
        vsync_nxt = (state_nxt == S_VSYNC);
        href_nxt  = (state_nxt == S_ACTIVE) && (h_nxt < H_ACT_LIM);
        d_nxt     = 8'h00;
`ifdef TEST_BARS_EN
        pix_x_even = {pix_x[HW-2:1], 1'b0};
        bar_k      = 3'(32'(pix_x) / BAR_W);
        bar_k_even = 3'(32'(pix_x_even) / BAR_W);
        if (href_nxt) begin
            case (byte_sel)
                2'd0:    d_nxt = bar_cb(bar_k_even);
                2'd2:    d_nxt = bar_cr(bar_k_even);
                default: d_nxt = bar_y(bar_k);
            endcase
        end
`else
        if (href_nxt) begin
            if (byte_sel[0] == 1'b0) begin
                d_nxt = 8'h80;
            end else begin
                d_nxt = 8'(pix_x) + 8'(line_nxt) + frame_cnt;
            end
        end
`endif
    end

    // Frame FSM with registered bus outputs; everything but PCLK moves on PCLK fall.
    always_ff @(posedge CLOCK_24 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            h_cnt      <= '0;
            line_cnt   <= '0;
            pclk_q     <= 1'b0;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            d_q        <= 8'h00;
            frame_cnt  <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            pclk_q     <= ~pclk_q;
            frame_done <= 1'b0;
            if (pclk_q) begin
                state    <= state_nxt;
                h_cnt    <= h_nxt;
                line_cnt <= line_nxt;
                vsync_q  <= vsync_nxt;
                href_q   <= href_nxt;
                d_q      <= d_nxt;
                if (frame_end) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule
